// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_pkg: shared PC-controller state encoding and default constants |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package core_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'hBFC0_0000;
  localparam int          INSTR_BYTES_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_resolve: combinational beq/bne decision and next-PC target   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module branch_resolve
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  branch_valid,
  input  logic                  branch_ne,
  input  logic [ADDR_WIDTH-1:0] branch_imm,
  input  logic                  EQ,
  output logic                  take,
  output logic [ADDR_WIDTH-1:0] target,
  output logic                  misaligned
);

  localparam logic [ADDR_WIDTH-1:0] c_step = ADDR_WIDTH'(INSTR_BYTES);

  // bne inverts the sense of the equality flag.
  assign take       = branch_valid & (EQ ^ branch_ne);
  assign target     = take ? (pc + branch_imm) : (pc + c_step);
  assign misaligned = |target[1:0];

endmodule
`default_nettype wire

// File: rtl/pc_branch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_branch_ctrl: PC sequencer, fetch handshake and branch resolution |
// | Optional macro BRANCH_STATS_EN adds saturating branch counters.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_branch_ctrl
  import core_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fetch_req,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_ack,
  input  logic                  branch_valid,
  input  logic                  branch_ne,
  input  logic [ADDR_WIDTH-1:0] branch_imm,
  input  logic                  halt,
  input  logic                  EQ,
  output logic                  ALUctrl,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  retire,
  output logic                  taken,
  output logic                  trap
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]           branch_cnt,
  output logic [15:0]           taken_cnt
`endif
);

  pc_state_t             r_state;
  pc_state_t             w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_retire;
  logic                  r_taken;
  logic                  r_trap;
  logic                  w_take;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_misaligned;

  branch_resolve #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_branch_resolve (
    .pc           (r_pc),
    .branch_valid (branch_valid),
    .branch_ne    (branch_ne),
    .branch_imm   (branch_imm),
    .EQ           (EQ),
    .take         (w_take),
    .target       (w_target),
    .misaligned   (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH:   if (fetch_ack) w_state_next = EXEC;
      EXEC:    w_state_next = (w_misaligned || halt) ? HALTED : FETCH;
      HALTED:  w_state_next = HALTED;
      default: w_state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_retire <= 1'b0;
      r_taken  <= 1'b0;
      r_trap   <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      r_taken  <= 1'b0;
      if (r_state == EXEC) begin
        r_retire <= 1'b1;
        r_taken  <= w_take;
        // A misaligned target leaves the PC pointing at the faulting instruction.
        if (w_misaligned) r_trap <= 1'b1;
        else              r_pc   <= w_target;
      end
    end
  end

  // Gating with rst_n drops the request the instant reset asserts.
  assign fetch_req  = (r_state == FETCH) && rst_n;
  assign fetch_addr = r_pc;
  assign ALUctrl    = (r_state == EXEC) && branch_valid;
  assign pc         = r_pc;
  assign retire     = r_retire;
  assign taken      = r_taken;
  assign trap       = r_trap;

`ifdef BRANCH_STATS_EN
  logic [15:0] r_branch_cnt;
  logic [15:0] r_taken_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt <= 16'h0000;
      r_taken_cnt  <= 16'h0000;
    end else if (r_state == EXEC) begin
      if (branch_valid && (r_branch_cnt != 16'hFFFF)) r_branch_cnt <= r_branch_cnt + 16'd1;
      if (w_take && (r_taken_cnt != 16'hFFFF))        r_taken_cnt  <= r_taken_cnt + 16'd1;
    end
  end

  assign branch_cnt = r_branch_cnt;
  assign taken_cnt  = r_taken_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pc_branch_ctrl: randomized self-checking bench for pc_branch_ctrl|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pc_branch_ctrl;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_ack = 1'b0;
  logic        branch_valid = 1'b0;
  logic        branch_ne = 1'b0;
  logic [31:0] branch_imm = 32'h0;
  logic        halt = 1'b0;
  logic        EQ = 1'b0;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        ALUctrl;
  logic [31:0] pc;
  logic        retire;
  logic        taken;
  logic        trap;

  pc_branch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .branch_valid (branch_valid),
    .branch_ne    (branch_ne),
    .branch_imm   (branch_imm),
    .halt         (halt),
    .EQ           (EQ),
    .ALUctrl      (ALUctrl),
    .pc           (pc),
    .retire       (retire),
    .taken        (taken),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural PC plus halted/trap status.
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_trap;
  bit          e_take;

  // Observations gathered by run_instr.
  bit          o_fetch_ok, o_alu, o_req_exec, o_early, o_retire, o_taken, o_trap, o_req_after;
  logic [31:0] o_pc;
  logic [7:0]  got_flags, exp_flags;

  task automatic apply_reset();
    rst_n = 1'b0;
    fetch_ack = 1'b0; branch_valid = 1'b0; branch_ne = 1'b0; halt = 1'b0; EQ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_pc = RPC; m_halted = 1'b0; m_trap = 1'b0;
  endtask

  // Drives one instruction: FETCH with 'waits' withheld-ack cycles, then EXEC.
  task automatic run_instr(input int waits, input bit bv, input bit ne, input bit eq,
                           input bit hlt, input logic [31:0] imm);
    logic [31:0] tgt;
    o_fetch_ok = 1'b1; o_early = 1'b0;
    for (int w = 0; w <= waits; w++) begin
      if (fetch_req !== 1'b1 || fetch_addr !== m_pc) o_fetch_ok = 1'b0;
      if (w > 0 && (retire !== 1'b0 || taken !== 1'b0)) o_early = 1'b1;
      fetch_ack    = (w == waits);
      branch_valid = 1'($urandom);
      branch_ne    = 1'($urandom);
      EQ           = 1'($urandom);
      halt         = 1'($urandom);
      branch_imm   = $urandom;
      #1;
      if (ALUctrl !== 1'b0) o_fetch_ok = 1'b0;
      @(negedge clk);
    end
    fetch_ack = 1'b1;
    branch_valid = bv; branch_ne = ne; EQ = eq; halt = hlt; branch_imm = imm;
    #1;
    o_alu = ALUctrl; o_req_exec = fetch_req;
    if (retire !== 1'b0 || taken !== 1'b0) o_early = 1'b1;
    // beq is taken on equal operands, bne on unequal ones.
    e_take = bv && (ne ? !eq : eq);
    tgt = e_take ? m_pc + imm : m_pc + 32'd4;
    if (tgt % 4 != 0) begin
      m_trap = 1'b1; m_halted = 1'b1;
    end else begin
      m_pc = tgt; m_halted = hlt;
    end
    @(negedge clk);
    o_retire = retire; o_taken = taken; o_pc = pc; o_trap = trap; o_req_after = fetch_req;
    fetch_ack = 1'b0; branch_valid = 1'b0; branch_ne = 1'b0; EQ = 1'b0; halt = 1'b0;
    got_flags = {o_fetch_ok, o_alu, o_req_exec, o_early, o_retire, o_taken, o_trap, o_req_after};
    exp_flags = {1'b1, bv, 1'b0, 1'b0, 1'b1, e_take, m_trap, !m_halted};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; branch_valid = 1'b1; fetch_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({fetch_req, ALUctrl, retire, taken, trap} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=00000", {fetch_req, ALUctrl, retire, taken, trap});
    end
    n_checks++;
    if (pc !== RPC || fetch_addr !== RPC) begin
      n_fail++; $display("FAIL reset_pc got=%h/%h exp=%h", pc, fetch_addr, RPC);
    end
    apply_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = RPC;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (fetch_addr !== exp_pc) begin
        n_fail++; $display("FAIL seq_fetch_addr[%0d] got=%h exp=%h", i, fetch_addr, exp_pc);
      end
      run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_pc = exp_pc + 32'd4;
      n_checks++;
      if (got_flags !== exp_flags || o_pc !== exp_pc) begin
        n_fail++; $display("FAIL seq_instr[%0d] flags=%b pc=%h exp flags=%b pc=%h", i, got_flags, o_pc, exp_flags, exp_pc);
      end
    end
  endtask

  task automatic test_beq_taken();
    apply_reset();
    for (int i = 0; i < 4; i++) run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (fetch_addr !== 32'hBFC0_0010) begin
      n_fail++; $display("FAIL beq_start got=%h exp=bfc00010", fetch_addr);
    end
    run_instr(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8);
    n_checks++;
    if (got_flags !== 8'b1100_1101 || o_pc !== 32'hBFC0_0008) begin
      n_fail++; $display("FAIL beq_taken flags=%b pc=%h exp flags=11001101 pc=bfc00008", got_flags, o_pc);
    end
  endtask

  task automatic test_bne_not_taken();
    apply_reset();
    run_instr(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd16);
    n_checks++;
    if (got_flags !== 8'b1100_1001 || o_pc !== 32'hBFC0_0004) begin
      n_fail++; $display("FAIL bne_not_taken flags=%b pc=%h exp flags=11001001 pc=bfc00004", got_flags, o_pc);
    end
  endtask

  task automatic test_ack_wait();
    logic [31:0] exp_pc;
    exp_pc = m_pc + 32'd4;
    run_instr(3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (got_flags !== 8'b1000_1001 || o_pc !== exp_pc) begin
      n_fail++; $display("FAIL ack_wait flags=%b pc=%h exp flags=10001001 pc=%h", got_flags, o_pc, exp_pc);
    end
  endtask

  task automatic test_misaligned();
    int bad;
    apply_reset();
    run_instr(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd6);
    n_checks++;
    if (got_flags !== 8'b1100_1110 || o_pc !== RPC) begin
      n_fail++; $display("FAIL misaligned flags=%b pc=%h exp flags=11001110 pc=%h", got_flags, o_pc, RPC);
    end
    bad = 0;
    fetch_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (fetch_req !== 1'b0 || trap !== 1'b1 || pc !== RPC || retire !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL halted_hold bad_cycles=%0d exp=0", bad);
    end
    apply_reset();
    n_checks++;
    if (trap !== 1'b0 || fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL trap_cleared trap=%b req=%b exp trap=0 req=1", trap, fetch_req);
    end
  endtask

  task automatic test_wrap_halt();
    int bad;
    apply_reset();
    run_instr(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h403F_FFFC);
    n_checks++;
    if (o_pc !== 32'hFFFF_FFFC || got_flags !== exp_flags) begin
      n_fail++; $display("FAIL wrap_setup pc=%h flags=%b exp pc=fffffffc flags=%b", o_pc, got_flags, exp_flags);
    end
    run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (o_pc !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap pc=%h exp=00000000", o_pc);
    end
    run_instr(2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    n_checks++;
    if (got_flags !== 8'b1000_1000 || o_pc !== 32'h0000_0004) begin
      n_fail++; $display("FAIL halt flags=%b pc=%h exp flags=10001000 pc=00000004", got_flags, o_pc);
    end
    bad = 0;
    fetch_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fetch_req !== 1'b0 || pc !== 32'h0000_0004) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL halt_hold bad_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset();
    run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (fetch_req !== 1'b0 || pc !== RPC) begin
      n_fail++; $display("FAIL reset_mid_fetch req=%b pc=%h exp req=0 pc=%h", fetch_req, pc, RPC);
    end
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    m_pc = RPC; m_halted = 1'b0; m_trap = 1'b0;
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== RPC || retire !== 1'b0) begin
      n_fail++; $display("FAIL reset_release req=%b addr=%h retire=%b exp req=1 addr=%h retire=0", fetch_req, fetch_addr, retire, RPC);
    end
  endtask

  task automatic test_random();
    logic [31:0] imm;
    bit bv, ne, eq, hlt;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      imm = ($urandom_range(0, 63) - 32) * 4;
      if ($urandom_range(0, 15) == 0) imm = imm + $urandom_range(1, 3);
      bv  = 1'($urandom);
      ne  = 1'($urandom);
      eq  = 1'($urandom);
      hlt = ($urandom_range(0, 15) == 0);
      run_instr(int'($urandom_range(0, 3)), bv, ne, eq, hlt, imm);
      n_checks++;
      if (got_flags !== exp_flags || o_pc !== m_pc) begin
        n_fail++; $display("FAIL random[%0d] flags=%b pc=%h exp flags=%b pc=%h", i, got_flags, o_pc, exp_flags, m_pc);
      end
      if (m_halted) apply_reset();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_wait();
    test_beq_taken();
    test_bne_not_taken();
    test_misaligned();
    test_wrap_halt();
    test_reset_mid_fetch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
